mem_access_seq: RTL and testbench

- Memory-access (MA) stage sequencer between the execute unit's memory request outputs and the data-cache port.
- Latches one load/store per instruction, drives the cache handshake, and stalls the pipeline until the cache completes.
- Sign/zero-extends load data and presents it for write-back.
- Reports misalignment, cache faults and timeouts as a one-cycle fault pulse.

---
 rtl/mem_access_seq_if.sv | 34 +++
 rtl/mem_access_seq.sv | 115 +++++++++++
 tb/tb_mem_access_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_seq_if.sv
// mem_access_seq_if: EX request, data-cache handshake and write-back bundle for the MA sequencer
interface mem_access_seq_if;
  logic        exMemLoad;
  logic        exMemStore;
  logic [31:0] exMemAddr;
  logic [31:0] exMemData;
  logic [1:0]  exMemSize;
  logic        exSignExt;
  logic [6:0]  exLoadRegId;
  logic        stall;
  logic [31:0] dcAddr;
  logic [31:0] dcDataOut;
  logic [1:0]  dcSize;
  logic        dcOE;
  logic        dcWE;
  logic [31:0] dcDataIn;
  logic [1:0]  dcOK;
  logic [6:0]  wbRegId;
  logic [31:0] wbRegVal;
  logic        wbValid;
  logic        fault;
  modport master (
    input  exMemLoad, exMemStore, exMemAddr, exMemData, exMemSize, exSignExt, exLoadRegId,
    input  dcDataIn, dcOK,
    output stall, dcAddr, dcDataOut, dcSize, dcOE, dcWE,
    output wbRegId, wbRegVal, wbValid, fault
  );
  modport slave (
    output exMemLoad, exMemStore, exMemAddr, exMemData, exMemSize, exSignExt, exLoadRegId,
    output dcDataIn, dcOK,
    input  stall, dcAddr, dcDataOut, dcSize, dcOE, dcWE,
    input  wbRegId, wbRegVal, wbValid, fault
  );
endinterface

// File: rtl/mem_access_seq.sv
// mem_access_seq: memory-access stage sequencer driving one cache access per EX load/store
module mem_access_seq #(
  parameter int         TIMEOUT  = 255,
  parameter logic [6:0] UREG_ZZR = 7'h3F
) (
  input logic            clock,
  input logic            reset,
  mem_access_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, FLT} stateT;
  stateT       state, stateNxt;
  logic [7:0]  cnt, cntNxt;
  logic [1:0]  lSize, lSizeNxt;
  logic        lSignExt, lSignExtNxt;
  logic [6:0]  lRegId, lRegIdNxt;
  logic        lStore, lStoreNxt;
  logic        oeNxt, weNxt, wbValidNxt, faultNxt;
  logic [31:0] addrNxt, dataNxt, wbRegValNxt, ldVal;
  logic [1:0]  sizeNxt;
  logic [6:0]  wbRegIdNxt;
  logic        req, bad;
  assign req = bus.exMemLoad | bus.exMemStore;
  assign bad = (bus.exMemLoad & bus.exMemStore) || bus.exMemSize == 2'd3 ||
               (bus.exMemSize == 2'd1 && bus.exMemAddr[0]) ||
               (bus.exMemSize == 2'd2 && bus.exMemAddr[1:0] != 2'b00);
  assign ldVal = lSize == 2'd0 ? {{24{lSignExt & bus.dcDataIn[7]}}, bus.dcDataIn[7:0]} :
                 lSize == 2'd1 ? {{16{lSignExt & bus.dcDataIn[15]}}, bus.dcDataIn[15:0]} :
                 bus.dcDataIn;
  assign bus.stall = !reset && ((state == IDLE && req) || state == BUSY);
  // next-state and next values of every registered output; DONE/FLT always fall back to IDLE
  always_comb begin
    stateNxt = state;
    cntNxt = '0;
    lSizeNxt = lSize;
    lSignExtNxt = lSignExt;
    lRegIdNxt = lRegId;
    lStoreNxt = lStore;
    oeNxt = bus.dcOE;
    weNxt = bus.dcWE;
    addrNxt = bus.dcAddr;
    dataNxt = bus.dcDataOut;
    sizeNxt = bus.dcSize;
    wbValidNxt = 1'b0;
    wbRegIdNxt = UREG_ZZR;
    wbRegValNxt = '0;
    faultNxt = 1'b0;
    case (state)
      IDLE: if (req) begin
        lSizeNxt = bus.exMemSize;
        lSignExtNxt = bus.exSignExt;
        lRegIdNxt = bus.exLoadRegId;
        lStoreNxt = bus.exMemStore;
        stateNxt = bad ? FLT : BUSY;
        faultNxt = bad;
        if (!bad) begin
          addrNxt = bus.exMemAddr;
          dataNxt = bus.exMemData;
          sizeNxt = bus.exMemSize;
          oeNxt = bus.exMemLoad;
          weNxt = bus.exMemStore;
        end
      end
      BUSY: if (bus.dcOK == 2'd1) begin
        stateNxt = DONE;
        oeNxt = 1'b0;
        weNxt = 1'b0;
        wbValidNxt = !lStore;
        wbRegIdNxt = lStore ? UREG_ZZR : lRegId;
        wbRegValNxt = lStore ? '0 : ldVal;
      end else if (bus.dcOK == 2'd3 || cnt == 8'(TIMEOUT - 1)) begin
        stateNxt = FLT;
        oeNxt = 1'b0;
        weNxt = 1'b0;
        faultNxt = 1'b1;
      end else cntNxt = cnt + 8'd1;
      default: stateNxt = IDLE;
    endcase
  end
  // state, latched request and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lSize <= '0;
      lSignExt <= 1'b0;
      lRegId <= UREG_ZZR;
      lStore <= 1'b0;
      bus.dcOE <= 1'b0;
      bus.dcWE <= 1'b0;
      bus.dcAddr <= '0;
      bus.dcDataOut <= '0;
      bus.dcSize <= '0;
      bus.wbValid <= 1'b0;
      bus.wbRegId <= UREG_ZZR;
      bus.wbRegVal <= '0;
      bus.fault <= 1'b0;
    end else begin
      state <= stateNxt;
      cnt <= cntNxt;
      lSize <= lSizeNxt;
      lSignExt <= lSignExtNxt;
      lRegId <= lRegIdNxt;
      lStore <= lStoreNxt;
      bus.dcOE <= oeNxt;
      bus.dcWE <= weNxt;
      bus.dcAddr <= addrNxt;
      bus.dcDataOut <= dataNxt;
      bus.dcSize <= sizeNxt;
      bus.wbValid <= wbValidNxt;
      bus.wbRegId <= wbRegIdNxt;
      bus.wbRegVal <= wbRegValNxt;
      bus.fault <= faultNxt;
    end
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed and randomized transactions checked against a transaction-level model
module tb_mem_access_seq;
  localparam int TO = 4;
  localparam logic [6:0] ZZR = 7'h3F;
  logic clock = 1'b0;
  logic reset;
  int nCmp = 0;
  int nFail = 0;
  mem_access_seq_if bus();
  mem_access_seq #(.TIMEOUT(TO), .UREG_ZZR(ZZR)) dut (.clock(clock), .reset(reset), .bus(bus.master));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    tick();
    bus.exMemLoad = 1'b0;
    bus.exMemStore = 1'b0;
    bus.dcOK = 2'd0;
    #1;
    chk("idleStall", 32'(bus.stall), 0);
    chk("idleWb", 32'(bus.wbValid), 0);
    chk("idleFault", 32'(bus.fault), 0);
    chk("idleOE", 32'(bus.dcOE), 0);
    chk("idleWE", 32'(bus.dcWE), 0);
  endtask
  // one whole instruction: accept, BUSY cycles, then the DONE/FLT cycle with the request still held
  task automatic access(input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] size, input logic sx, input logic [6:0] rid,
                        input int holds, input logic [1:0] fin, input logic [31:0] rdata);
    logic bad, flt;
    int busy;
    logic [31:0] ev;
    bad = (ld && st) || size == 2'd3 || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    busy = bad ? 0 : (holds >= TO ? TO : holds + 1);
    flt = bad || holds >= TO || fin == 2'd3;
    if (size == 2'd0) begin
      ev = rdata & 32'hFF;
      if (sx && ev >= 128) ev = ev - 256;
    end else if (size == 2'd1) begin
      ev = rdata & 32'hFFFF;
      if (sx && ev >= 32768) ev = ev - 65536;
    end else ev = rdata;
    tick();
    bus.exMemLoad = ld;
    bus.exMemStore = st;
    bus.exMemAddr = addr;
    bus.exMemData = data;
    bus.exMemSize = size;
    bus.exSignExt = sx;
    bus.exLoadRegId = rid;
    bus.dcOK = 2'd0;
    bus.dcDataIn = $urandom;
    #1;
    chk("accStall", 32'(bus.stall), 1);
    chk("accOE", 32'(bus.dcOE), 0);
    chk("accWE", 32'(bus.dcWE), 0);
    for (int k = 0; k < busy; k++) begin
      tick();
      bus.dcOK = k < holds ? ($urandom_range(0, 1) != 0 ? 2'd2 : 2'd0) : fin;
      bus.dcDataIn = k < holds ? $urandom : rdata;
      #1;
      chk("busyStall", 32'(bus.stall), 1);
      chk("busyOE", 32'(bus.dcOE), 32'(ld));
      chk("busyWE", 32'(bus.dcWE), 32'(st));
      chk("busyAddr", bus.dcAddr, addr);
      chk("busySize", 32'(bus.dcSize), 32'(size));
      if (st) chk("busyData", bus.dcDataOut, data);
      chk("busyFault", 32'(bus.fault), 0);
    end
    tick();
    bus.dcOK = 2'd0;
    bus.dcDataIn = $urandom;
    #1;
    chk("endStall", 32'(bus.stall), 0);
    chk("endOE", 32'(bus.dcOE), 0);
    chk("endWE", 32'(bus.dcWE), 0);
    chk("endFault", 32'(bus.fault), 32'(flt));
    chk("endWbValid", 32'(bus.wbValid), 32'(!flt && ld));
    if (!flt) chk("endWbRegId", 32'(bus.wbRegId), 32'(ld ? rid : ZZR));
    if (!flt && ld) chk("endWbRegVal", bus.wbRegVal, ev);
  endtask
  initial begin
    reset = 1'b1;
    bus.exMemLoad = 1'b0;
    bus.exMemStore = 1'b0;
    bus.exMemAddr = '0;
    bus.exMemData = '0;
    bus.exMemSize = '0;
    bus.exSignExt = 1'b0;
    bus.exLoadRegId = '0;
    bus.dcDataIn = '0;
    bus.dcOK = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rstStall", 32'(bus.stall), 0);
    chk("rstOE", 32'(bus.dcOE), 0);
    chk("rstWE", 32'(bus.dcWE), 0);
    chk("rstAddr", bus.dcAddr, 0);
    chk("rstDataOut", bus.dcDataOut, 0);
    chk("rstSize", 32'(bus.dcSize), 0);
    chk("rstWbValid", 32'(bus.wbValid), 0);
    chk("rstWbRegId", 32'(bus.wbRegId), 32'(ZZR));
    chk("rstWbRegVal", bus.wbRegVal, 0);
    chk("rstFault", 32'(bus.fault), 0);
    access(1, 0, 32'h1000, 0, 2'd2, 0, 7'd5, 0, 2'd1, 32'hDEADBEEF);
    idle();
    access(1, 0, 32'h1003, 0, 2'd0, 1, 7'd9, 0, 2'd1, 32'h000000F0);
    access(1, 0, 32'h1003, 0, 2'd0, 0, 7'd10, 0, 2'd1, 32'h000000F0);
    access(1, 0, 32'h1002, 0, 2'd1, 1, 7'd11, 1, 2'd1, 32'h00008001);
    idle();
    access(0, 1, 32'h2002, 32'h1234, 2'd1, 0, 7'd3, 3, 2'd1, 32'hFFFFFFFF);
    idle();
    access(1, 0, 32'h1001, 0, 2'd2, 0, 7'd4, 0, 2'd1, 0);
    access(1, 0, 32'h1000, 0, 2'd3, 0, 7'd4, 0, 2'd1, 0);
    access(1, 1, 32'h1000, 32'h55, 2'd2, 0, 7'd4, 0, 2'd1, 0);
    idle();
    access(1, 0, 32'h3000, 0, 2'd2, 0, 7'd6, 10, 2'd1, 0);
    access(0, 1, 32'h3004, 32'hA5A5, 2'd2, 0, 7'd6, 1, 2'd3, 0);
    idle();
    tick();
    bus.exMemLoad = 1'b1;
    bus.exMemStore = 1'b0;
    bus.exMemAddr = 32'h4000;
    bus.exMemSize = 2'd2;
    bus.exLoadRegId = 7'd7;
    bus.dcOK = 2'd2;
    tick();
    #1;
    chk("rbBusyOE", 32'(bus.dcOE), 1);
    tick();
    reset = 1'b1;
    #1;
    chk("rbRstStall", 32'(bus.stall), 0);
    chk("rbRstOE", 32'(bus.dcOE), 1);
    tick();
    reset = 1'b0;
    bus.exMemLoad = 1'b0;
    bus.dcOK = 2'd1;
    #1;
    chk("rbOE", 32'(bus.dcOE), 0);
    chk("rbWbValid", 32'(bus.wbValid), 0);
    chk("rbFault", 32'(bus.fault), 0);
    chk("rbWbRegId", 32'(bus.wbRegId), 32'(ZZR));
    idle();
    for (int i = 0; i < 40; i++) begin
      logic ld, st, sx;
      logic [1:0] sz, fin;
      logic [31:0] a;
      int r, h;
      r = $urandom_range(0, 9);
      ld = r < 5 || r == 9;
      st = r >= 5;
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a = sz == 2'd1 ? a & ~32'h1 : sz == 2'd2 ? a & ~32'h3 : a;
      h = $urandom_range(0, 5);
      fin = $urandom_range(0, 5) == 0 ? 2'd3 : 2'd1;
      sx = 1'($urandom_range(0, 1));
      access(ld, st, a, $urandom, sz, sx, 7'($urandom_range(0, 127)), h, fin, $urandom);
      if ($urandom_range(0, 1) != 0) idle();
    end
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
